// File: rtl/traj_point_arbiter.sv
// traj_point_arbiter: round-robin share of the trajectory overlay point between tracker (req0) and cursor (req1),
// committed at the end-of-active-frame boundary. Optional stale-marker clear: define TRAJ_ARB_STALE_CLEAR_EN.
module traj_point_arbiter #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int STALE_FRAMES = 30
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_h,
  input  logic [9:0] i_v,
  input  logic [9:0] i_req0_h,
  input  logic [9:0] i_req0_v,
  input  logic       i_req0_valid,
  output logic       o_req0_ready,
  input  logic [9:0] i_req1_h,
  input  logic [9:0] i_req1_v,
  input  logic       i_req1_valid,
  output logic       o_req1_ready,
  output logic [9:0] o_pointH,
  output logic [9:0] o_pointV,
  output logic       o_pointVAL,
  output logic       o_src,
  output logic [7:0] o_drop_cnt
);

  localparam logic [9:0] H_LIMIT   = 10'(FRAME_WIDTH);
  localparam logic [9:0] V_LIMIT   = 10'(FRAME_HEIGHT);
  localparam logic [9:0] V_LAST    = 10'(FRAME_HEIGHT - 1);
  localparam logic [9:0] OFFSCREEN = 10'h3FF;
  localparam logic [7:0] STALE_LAST = 8'(STALE_FRAMES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t     state_r;
  logic [9:0] v_prev_r;
  logic       last_grant_r;
  logic [9:0] pend_h_r;
  logic [9:0] pend_v_r;
  logic       pend_src_r;
  logic [9:0] point_h_r;
  logic [9:0] point_v_r;
  logic       point_val_r;
  logic       src_r;
  logic [7:0] drop_cnt_r;

  logic       bnd_s;
  logic       commit_s;
  logic       accept_s;
  logic       grant_s;
  logic [9:0] sel_h_s;
  logic [9:0] sel_v_s;
  logic       in_range_s;
  logic       stale_fire_s;

  // The scan column carries no information for this block; sink it so it is visibly intentional.
  logic unused_h_s;
  assign unused_h_s = ^i_h;

  // Boundary detect, round-robin grant and range check of the granted point.
  always_comb begin
    bnd_s      = (v_prev_r == V_LAST) && (i_v != V_LAST);
    commit_s   = (state_r == PEND) && bnd_s;
    accept_s   = 1'b0;
    grant_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req0_valid && i_req1_valid) begin
          accept_s = 1'b1;
          grant_s  = ~last_grant_r;
        end else if (i_req0_valid) begin
          accept_s = 1'b1;
          grant_s  = 1'b0;
        end else if (i_req1_valid) begin
          accept_s = 1'b1;
          grant_s  = 1'b1;
        end else begin
          accept_s = 1'b0;
          grant_s  = 1'b0;
        end
      end
      PEND: begin
        accept_s = 1'b0;
        grant_s  = 1'b0;
      end
      default: begin
        accept_s = 1'b0;
        grant_s  = 1'b0;
      end
    endcase
    sel_h_s    = grant_s ? i_req1_h : i_req0_h;
    sel_v_s    = grant_s ? i_req1_v : i_req0_v;
    in_range_s = (sel_h_s < H_LIMIT) && (sel_v_s < V_LIMIT);
  end

  assign o_req0_ready = accept_s & ~grant_s;
  assign o_req1_ready = accept_s & grant_s;

`ifdef TRAJ_ARB_STALE_CLEAR_EN
  logic [7:0] stale_cnt_r;

  assign stale_fire_s = bnd_s && !commit_s && (stale_cnt_r == STALE_LAST);

  // Frames elapsed since the last commit; a clear restarts the count like a commit does.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stale_cnt_r <= 8'd0;
    end else if (commit_s || stale_fire_s) begin
      stale_cnt_r <= 8'd0;
    end else if (bnd_s) begin
      stale_cnt_r <= stale_cnt_r + 8'd1;
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^STALE_LAST;
  assign stale_fire_s = 1'b0;
`endif

  // Arbitration FSM with the pending slot and the registered overlay outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      v_prev_r     <= 10'd0;
      last_grant_r <= 1'b1;
      pend_h_r     <= OFFSCREEN;
      pend_v_r     <= OFFSCREEN;
      pend_src_r   <= 1'b0;
      point_h_r    <= OFFSCREEN;
      point_v_r    <= OFFSCREEN;
      point_val_r  <= 1'b0;
      src_r        <= 1'b0;
      drop_cnt_r   <= 8'd0;
    end else begin
      v_prev_r    <= i_v;
      point_val_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            last_grant_r <= grant_s;
            if (in_range_s) begin
              pend_h_r   <= sel_h_s;
              pend_v_r   <= sel_v_s;
              pend_src_r <= grant_s;
              state_r    <= PEND;
            end else if (drop_cnt_r != 8'hFF) begin
              drop_cnt_r <= drop_cnt_r + 8'd1;
            end
          end
        end
        PEND: begin
          if (commit_s) begin
            point_h_r   <= pend_h_r;
            point_v_r   <= pend_v_r;
            src_r       <= pend_src_r;
            point_val_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
      // Never coincides with a commit, so the commit always has priority.
      if (stale_fire_s) begin
        point_h_r   <= OFFSCREEN;
        point_v_r   <= OFFSCREEN;
        point_val_r <= 1'b1;
      end
    end
  end

  assign o_pointH   = point_h_r;
  assign o_pointV   = point_v_r;
  assign o_pointVAL = point_val_r;
  assign o_src      = src_r;
  assign o_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_traj_point_arbiter.sv
// Self-checking bench for traj_point_arbiter: randomized sources checked against a queue-based frame model.
module tb_traj_point_arbiter;

  localparam int STALE = 3;

  logic       i_clk, i_rst_n;
  logic [9:0] i_h, i_v;
  logic [9:0] i_req0_h, i_req0_v, i_req1_h, i_req1_v;
  logic       i_req0_valid, i_req1_valid;
  logic       o_req0_ready, o_req1_ready;
  logic [9:0] o_pointH, o_pointV;
  logic       o_pointVAL, o_src;
  logic [7:0] o_drop_cnt;

  traj_point_arbiter #(.FRAME_WIDTH(640), .FRAME_HEIGHT(480), .STALE_FRAMES(STALE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_h(i_h), .i_v(i_v),
    .i_req0_h(i_req0_h), .i_req0_v(i_req0_v), .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req1_h(i_req1_h), .i_req1_v(i_req1_v), .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .o_pointH(o_pointH), .o_pointV(o_pointV), .o_pointVAL(o_pointVAL), .o_src(o_src), .o_drop_cnt(o_drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_chk  = 0;
  int line, v_lo, v_hi;
  logic obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1;
  logic [31:0] obs_vec, exp_vec;

  // Reference model: a one-deep queue of accepted points drained at each frame boundary.
  typedef struct packed { logic [9:0] h; logic [9:0] v; logic src; } pt_t;
  pt_t        pend_q[$];
  int         m_last, m_drop, m_stale;
  logic [9:0] m_h, m_v, m_vprev;
  logic       m_val, m_src;

  task automatic model_reset();
    pend_q.delete();
    m_last = 1; m_drop = 0; m_stale = 0;
    m_h = 10'h3FF; m_v = 10'h3FF; m_vprev = 10'd0; m_val = 1'b0; m_src = 1'b0;
  endtask

  function automatic int winner();
    if (pend_q.size() != 0) return -1;
    if (i_req0_valid && i_req1_valid) return (m_last == 0) ? 1 : 0;
    if (i_req0_valid) return 0;
    if (i_req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_advance(input int w);
    pt_t  p;
    logic bnd, done;
    bnd  = (m_vprev == 10'd479) && (i_v != 10'd479);
    done = 1'b0;
    m_val = 1'b0;
    if (bnd && pend_q.size() != 0) begin
      p = pend_q.pop_front();
      m_h = p.h; m_v = p.v; m_src = p.src; m_val = 1'b1; done = 1'b1;
    end else if (w >= 0) begin
      m_last = w;
      p.h = (w == 1) ? i_req1_h : i_req0_h;
      p.v = (w == 1) ? i_req1_v : i_req0_v;
      p.src = (w == 1);
      if (p.h < 10'd640 && p.v < 10'd480) pend_q.push_back(p);
      else if (m_drop < 255) m_drop++;
    end
`ifdef TRAJ_ARB_STALE_CLEAR_EN
    if (done) m_stale = 0;
    else if (bnd) begin
      m_stale++;
      if (m_stale == STALE) begin
        m_h = 10'h3FF; m_v = 10'h3FF; m_val = 1'b1; m_stale = 0;
      end
    end
`endif
    m_vprev = i_v;
  endtask

  // One pixel-clock step: apply scan line, sample readies at negedge, outputs 1 unit after posedge.
  task automatic clk_step();
    int w;
    i_v  = 10'(line);
    i_h  = 10'($urandom_range(0, 799));
    line = (line == v_hi) ? v_lo : line + 1;
    @(negedge i_clk);
    w = winner();
    exp_rdy0 = (w == 0); exp_rdy1 = (w == 1);
    obs_rdy0 = o_req0_ready; obs_rdy1 = o_req1_ready;
    model_advance(w);
    @(posedge i_clk); #1;
    obs_vec = {obs_rdy0, obs_rdy1, o_pointH, o_pointV, o_pointVAL, o_src, o_drop_cnt};
    exp_vec = {exp_rdy0, exp_rdy1, m_h, m_v, m_val, m_src, 8'(m_drop)};
  endtask

  task automatic do_reset();
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();
    v_lo = 0; v_hi = 524; line = 0;
  endtask

  task automatic test_reset();
    int pulses;
    i_rst_n = 1'b1; i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_v = 10'd0; i_h = 10'd0;
    i_req0_h = 10'd0; i_req0_v = 10'd0; i_req1_h = 10'd0; i_req1_v = 10'd0;
    #2 i_rst_n = 1'b0;
    #2;
    n_chk++;
    if ({o_req0_ready, o_req1_ready, o_pointH, o_pointV, o_pointVAL, o_src, o_drop_cnt} !==
        {1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 8'd0})
      $display("FAIL reset_values got %h want %h",
               {o_req0_ready, o_req1_ready, o_pointH, o_pointV, o_pointVAL, o_src, o_drop_cnt},
               {1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 8'd0});
    else n_pass++;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();
    v_lo = 0; v_hi = 524; line = 0;
    pulses = 0;
    for (int i = 0; i < 525; i++) begin
      clk_step();
      if (o_pointVAL) pulses++;
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL idle_sweep cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else n_pass++;
    end
    n_chk++;
    if ({pulses, o_pointH, o_pointV, o_drop_cnt} !== {32'd0, 10'h3FF, 10'h3FF, 8'd0})
      $display("FAIL idle_final got pulses=%0d pt=%h/%h drop=%0d want 0 3ff/3ff 0", pulses, o_pointH, o_pointV, o_drop_cnt);
    else n_pass++;
  endtask

  task automatic test_single();
    int rdy_cnt, pulses, pulse_v;
    logic [20:0] pulse_pt;
    rdy_cnt = 0; pulses = 0; pulse_v = -1; pulse_pt = '0;
    for (int g = 0; g < 600 && line != 10; g++) begin
      clk_step();
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL single_lead got %h want %h", obs_vec, exp_vec);
      else n_pass++;
    end
    i_req0_h = 10'd100; i_req0_v = 10'd50; i_req0_valid = 1'b1;
    for (int i = 0; i < 1050; i++) begin
      clk_step();
      if (obs_rdy0) begin rdy_cnt++; i_req0_valid = 1'b0; end
      if (o_pointVAL) begin pulses++; pulse_v = int'(i_v); pulse_pt = {o_pointH, o_pointV, o_src}; end
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL single_cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else n_pass++;
    end
    n_chk++;
    if (rdy_cnt !== 1) $display("FAIL single_ready_cnt got %0d want 1", rdy_cnt);
    else n_pass++;
    n_chk++;
    if (pulses !== 1 || pulse_v !== 480) $display("FAIL single_strobe got %0d pulses at v=%0d want 1 at v=480", pulses, pulse_v);
    else n_pass++;
    n_chk++;
    if (pulse_pt !== {10'd100, 10'd50, 1'b0}) $display("FAIL single_point got %h want %h", pulse_pt, {10'd100, 10'd50, 1'b0});
    else n_pass++;
  endtask

  task automatic test_alternate();
    int srcs[3];
    int commits;
    do_reset();
    commits = 0;
    for (int g = 0; g < 600 && line != 20; g++) begin
      clk_step();
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL alt_lead got %h want %h", obs_vec, exp_vec);
      else n_pass++;
    end
    i_req0_h = 10'($urandom_range(0, 319));   i_req0_v = 10'($urandom_range(0, 479)); i_req0_valid = 1'b1;
    i_req1_h = 10'($urandom_range(320, 639)); i_req1_v = 10'($urandom_range(0, 479)); i_req1_valid = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      clk_step();
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL alt_cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else n_pass++;
      if (o_pointVAL && commits < 3) begin srcs[commits] = int'(o_src); commits++; end
      if (obs_rdy0) begin i_req0_h = 10'($urandom_range(0, 319));   i_req0_v = 10'($urandom_range(0, 479)); end
      if (obs_rdy1) begin i_req1_h = 10'($urandom_range(320, 639)); i_req1_v = 10'($urandom_range(0, 479)); end
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    n_chk++;
    if (commits !== 3 || srcs[0] !== 0 || srcs[1] !== 1 || srcs[2] !== 0)
      $display("FAIL alt_order got %0d commits src %0d,%0d,%0d want 3 commits 0,1,0", commits, srcs[0], srcs[1], srcs[2]);
    else n_pass++;
  endtask

  task automatic test_drop();
    int idx, pulses;
    do_reset();
    idx = 0; pulses = 0;
    for (int i = 0; i < 2000 && idx < 302; i++) begin
      if (idx == 0) begin i_req1_h = 10'd700; i_req1_v = 10'd20; end
      else if (idx == 1) begin i_req1_h = 10'd10; i_req1_v = 10'd490; end
      else if (!i_req1_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          i_req1_h = 10'($urandom_range(640, 1023)); i_req1_v = 10'($urandom_range(0, 1023));
        end else begin
          i_req1_h = 10'($urandom_range(0, 1023)); i_req1_v = 10'($urandom_range(480, 1023));
        end
      end
      i_req1_valid = 1'b1;
      clk_step();
      if (obs_rdy1) begin idx++; i_req1_valid = 1'b0; end
      if (o_pointVAL) pulses++;
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL drop_cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else n_pass++;
    end
    i_req1_valid = 1'b0;
    n_chk++;
    if (idx !== 302) $display("FAIL drop_accepts got %0d want 302", idx);
    else n_pass++;
    n_chk++;
    if (o_drop_cnt !== 8'd255 || pulses !== 0) $display("FAIL drop_saturate got cnt=%0d pulses=%0d want 255 0", o_drop_cnt, pulses);
    else n_pass++;
  endtask

  task automatic test_bnd_accept();
    int found, pv;
    do_reset();
    found = -1; pv = -1;
    for (int g = 0; g < 600 && line != 480; g++) begin
      clk_step();
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL bnd_lead got %h want %h", obs_vec, exp_vec);
      else n_pass++;
    end
    i_req0_h = 10'd200; i_req0_v = 10'd100; i_req0_valid = 1'b1;
    clk_step();
    i_req0_valid = 1'b0;
    n_chk++;
    if ({obs_rdy0, o_pointVAL} !== 2'b10) $display("FAIL bnd_accept got rdy=%b val=%b want 1 0", obs_rdy0, o_pointVAL);
    else n_pass++;
    for (int k = 1; k <= 600; k++) begin
      clk_step();
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL bnd_cyc %0d got %h want %h", k, obs_vec, exp_vec);
      else n_pass++;
      if (o_pointVAL) begin found = k; pv = int'(i_v); break; end
    end
    n_chk++;
    if (found !== 525 || pv !== 480 || o_pointH !== 10'd200 || o_pointV !== 10'd100)
      $display("FAIL bnd_deferred got step=%0d v=%0d pt=%0d/%0d want 525 480 200/100", found, pv, o_pointH, o_pointV);
    else n_pass++;
  endtask

  task automatic test_reset_pend();
    int pulses;
    pulses = 0;
    for (int g = 0; g < 600 && line != 30; g++) begin
      clk_step();
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL rstp_lead got %h want %h", obs_vec, exp_vec);
      else n_pass++;
    end
    i_req1_h = 10'd321; i_req1_v = 10'd222; i_req1_valid = 1'b1;
    clk_step();
    i_req1_valid = 1'b0;
    n_chk++;
    if (obs_rdy1 !== 1'b1) $display("FAIL rstp_accept got %b want 1", obs_rdy1);
    else n_pass++;
    for (int i = 0; i < 5; i++) clk_step();
    #2 i_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_pointH, o_pointV, o_pointVAL, o_src, o_drop_cnt} !== {10'h3FF, 10'h3FF, 1'b0, 1'b0, 8'd0})
      $display("FAIL rstp_async got %h want %h", {o_pointH, o_pointV, o_pointVAL, o_src, o_drop_cnt},
               {10'h3FF, 10'h3FF, 1'b0, 1'b0, 8'd0});
    else n_pass++;
    model_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    line = 0;
    for (int i = 0; i < 600; i++) begin
      clk_step();
      if (o_pointVAL) pulses++;
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL rstp_cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else n_pass++;
    end
    n_chk++;
    if (pulses !== 0 || o_pointH !== 10'h3FF || o_pointV !== 10'h3FF)
      $display("FAIL rstp_lost got pulses=%0d pt=%h/%h want 0 3ff/3ff", pulses, o_pointH, o_pointV);
    else n_pass++;
  endtask

  task automatic test_stale();
    int pulses;
    logic [19:0] first_pt, last_pt;
    do_reset();
    pulses = 0; first_pt = '0; last_pt = '0;
    for (int g = 0; g < 600 && line != 10; g++) begin
      clk_step();
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL stale_lead got %h want %h", obs_vec, exp_vec);
      else n_pass++;
    end
    i_req0_h = 10'd5; i_req0_v = 10'd5; i_req0_valid = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      clk_step();
      if (obs_rdy0) i_req0_valid = 1'b0;
      if (o_pointVAL) begin
        if (pulses == 0) first_pt = {o_pointH, o_pointV};
        last_pt = {o_pointH, o_pointV};
        pulses++;
      end
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL stale_cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else n_pass++;
    end
    n_chk++;
    if (first_pt !== {10'd5, 10'd5}) $display("FAIL stale_commit got %h want %h", first_pt, {10'd5, 10'd5});
    else n_pass++;
`ifdef TRAJ_ARB_STALE_CLEAR_EN
    n_chk++;
    if (pulses !== 2 || last_pt !== {10'h3FF, 10'h3FF} || o_pointH !== 10'h3FF)
      $display("FAIL stale_clear got pulses=%0d last=%h want 2 %h", pulses, last_pt, {10'h3FF, 10'h3FF});
    else n_pass++;
`else
    n_chk++;
    if (pulses !== 1 || {o_pointH, o_pointV} !== {10'd5, 10'd5})
      $display("FAIL stale_hold got pulses=%0d pt=%0d/%0d want 1 5/5", pulses, o_pointH, o_pointV);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    do_reset();
    v_lo = 470; v_hi = 490; line = 470;
    for (int i = 0; i < 3000; i++) begin
      if (!i_req0_valid && $urandom_range(0, 3) == 0) begin
        i_req0_valid = 1'b1;
        i_req0_h = 10'($urandom_range(0, 9) == 0 ? $urandom_range(640, 1023) : $urandom_range(0, 639));
        i_req0_v = 10'($urandom_range(0, 9) == 0 ? $urandom_range(480, 1023) : $urandom_range(0, 479));
      end
      if (!i_req1_valid && $urandom_range(0, 3) == 0) begin
        i_req1_valid = 1'b1;
        i_req1_h = 10'($urandom_range(0, 9) == 0 ? $urandom_range(640, 1023) : $urandom_range(0, 639));
        i_req1_v = 10'($urandom_range(0, 9) == 0 ? $urandom_range(480, 1023) : $urandom_range(0, 479));
      end
      clk_step();
      if (obs_rdy0) i_req0_valid = 1'b0;
      if (obs_rdy1) i_req1_valid = 1'b0;
      n_chk++;
      if (obs_vec !== exp_vec) $display("FAIL random_cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else n_pass++;
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_drop();
    test_bnd_accept();
    test_reset_pend();
    test_stale();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
